// File: rtl/audio_sample_fetch_if.sv
// ROM read bus and PWM sample output of audio_sample_fetch, as one bundle.
// rom_rd is a one-cycle strobe and rom_data is valid ROM_LAT cycles later; sample_valid pulses once per new sample.
`timescale 1ns/1ps
interface audio_sample_fetch_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rd;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] sample;
  logic              sample_valid;

  modport master (
    output rom_addr,
    output rom_rd,
    output sample,
    output sample_valid,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    input  rom_rd,
    input  sample,
    input  sample_valid,
    output rom_data
  );
endinterface

// File: rtl/audio_sample_fetch.sv
// Steps through a sample-ROM range, issuing one read every DIV clocks and
// holding the returned word for the PWM stage.
`timescale 1ns/1ps
module audio_sample_fetch #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int DIV     = 1024,
  parameter int ROM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  loop,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W-1:0]     end_addr,
  audio_sample_fetch_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_WAIT_TICK = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIV - 1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'((ROM_LAT > 0) ? ROM_LAT - 1 : 0);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cur;
  logic [ADDR_W-1:0]   r_start;
  logic [ADDR_W-1:0]   r_last;
  logic [CNT_W-1:0]    r_tick_cnt;
  logic [LAT_W-1:0]    r_lat_cnt;
  logic [DATA_W-1:0]   r_sample;
  logic                r_sample_valid;
  logic                w_cap;
  logic                w_tick;
  logic                w_at_last;

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_tick      = (r_tick_cnt == TICK_LAST);
    w_at_last   = (r_cur == r_last);
    case (r_state)
      S_IDLE:      if (en) w_state_nxt = S_FETCH;
      S_FETCH:     if (ROM_LAT == 0) w_cap = 1'b1;
                   else w_state_nxt = S_WAIT_DATA;
      S_WAIT_DATA: if (r_lat_cnt == LAT_LAST) w_cap = 1'b1;
      S_WAIT_TICK: if (w_tick) w_state_nxt = S_FETCH;
      S_DONE:      w_state_nxt = S_DONE;
      default:     w_state_nxt = S_IDLE;
    endcase
    if (w_cap) w_state_nxt = (w_at_last && !loop) ? S_DONE : S_WAIT_TICK;
    // Dropping en aborts from anywhere and discards a capture on the same edge.
    if (!en) begin
      w_state_nxt = S_IDLE;
      w_cap       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur          <= '0;
      r_start        <= '0;
      r_last         <= '0;
      r_tick_cnt     <= '0;
      r_lat_cnt      <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= w_cap;
      // The tick counter free-runs while busy so reads stay exactly DIV apart.
      if (r_state == S_IDLE) begin
        r_tick_cnt <= '0;
        if (en) begin
          r_cur   <= start_addr;
          r_start <= start_addr;
          r_last  <= end_addr;
        end
      end else begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      end
      if (r_state == S_FETCH)          r_lat_cnt <= '0;
      else if (r_state == S_WAIT_DATA) r_lat_cnt <= r_lat_cnt + 1'b1;
      if (w_cap) begin
        r_sample <= bus.rom_data;
        r_cur    <= w_at_last ? r_start : r_cur + 1'b1;
      end else if (!en && r_state != S_IDLE) begin
        r_sample <= '0;
      end
    end
  end

  assign bus.rom_addr     = r_cur;
  assign bus.rom_rd       = (r_state == S_FETCH) && en;
  assign bus.sample       = r_sample;
  assign bus.sample_valid = r_sample_valid;
  assign busy             = (r_state != S_IDLE);
  assign done             = (r_state == S_DONE);
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_audio_sample_fetch.sv
// Bench for audio_sample_fetch: four instances (ROM latency 1/0/3 at 10-bit
// address, latency 1 at 4-bit address) run side by side against a timing model.
`timescale 1ns/1ps
module tb_audio_sample_fetch;

  localparam int DIV = 8;
  localparam int DW  = 32;
  localparam int ND  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        loop_i = 1'b0;
  logic [9:0]  start_i = '0;
  logic [9:0]  end_i = '0;
  logic [31:0] salt = 32'd16;
  logic [31:0] cyc = '0;

  int n_checks = 0;
  int n_errs   = 0;
  int m_start  = 0;
  int m_end    = 0;
  bit m_loop   = 1'b0;

  logic          obs_rd     [ND];
  logic [9:0]    obs_addr   [ND];
  logic [DW-1:0] obs_sample [ND];
  logic          obs_valid  [ND];
  logic          obs_busy   [ND];
  logic          obs_done   [ND];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rom_fn(input logic [31:0] a, input logic [31:0] s);
    return a + s;
  endfunction

  function automatic logic [DW-1:0] junk_fn(input logic [31:0] c);
    return 32'hBAD0_0000 | (c & 32'h0000_FFFF);
  endfunction

  function automatic int aw_of(input int i);
    return (i == 3) ? 4 : 10;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 1) ? 0 : (i == 2) ? 3 : 1;
  endfunction

  // ---------------- DUTs and ROM models ----------------
  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int LAT = (g == 1) ? 0 : (g == 2) ? 3 : 1;
    localparam int AW  = (g == 3) ? 4 : 10;

    audio_sample_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    logic          busy_w;
    logic          done_w;
    logic [2:0]    state_w;
    logic [DW-1:0] pipe [1:3];

    audio_sample_fetch #(
      .ADDR_W(AW), .DATA_W(DW), .DIV(DIV), .ROM_LAT(LAT)
    ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .loop(loop_i),
      .start_addr(start_i[AW-1:0]),
      .end_addr(end_i[AW-1:0]),
      .bus(bus),
      .busy(busy_w),
      .done(done_w),
      .dbg_state(state_w)
    );

    always @(posedge clk) begin
      pipe[1] <= bus.rom_rd ? rom_fn(32'(bus.rom_addr), salt) : junk_fn(cyc);
      pipe[2] <= pipe[1];
      pipe[3] <= pipe[2];
    end

    assign bus.rom_data = (LAT == 0) ?
      (bus.rom_rd ? rom_fn(32'(bus.rom_addr), salt) : junk_fn(cyc)) :
      pipe[(LAT == 0) ? 1 : LAT];

    assign obs_rd[g]     = bus.rom_rd;
    assign obs_addr[g]   = 10'(bus.rom_addr);
    assign obs_sample[g] = bus.sample;
    assign obs_valid[g]  = bus.sample_valid;
    assign obs_busy[g]   = busy_w;
    assign obs_done[g]   = done_w;
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string why, input bit with_addr);
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("%s d%0d rd", why, i), 64'(obs_rd[i]), 64'd0);
      chk($sformatf("%s d%0d valid", why, i), 64'(obs_valid[i]), 64'd0);
      chk($sformatf("%s d%0d sample", why, i), 64'(obs_sample[i]), 64'd0);
      chk($sformatf("%s d%0d busy", why, i), 64'(obs_busy[i]), 64'd0);
      chk($sformatf("%s d%0d done", why, i), 64'(obs_done[i]), 64'd0);
      if (with_addr) chk($sformatf("%s d%0d addr", why, i), 64'(obs_addr[i]), 64'd0);
    end
  endtask

  // t counts cycles since the IDLE exit edge: read k is issued in cycle
  // 1+k*DIV and its sample appears in cycle 2+LAT+k*DIV.
  task automatic check_cycle(input int t);
    for (int i = 0; i < ND; i++) begin
      int m, s, e, len, lat, k, ph;
      bit e_rd, e_val, e_done;
      int e_addr;
      logic [DW-1:0] e_smp;
      m   = 1 << aw_of(i);
      s   = m_start % m;
      e   = m_end % m;
      len = ((e + m - s) % m) + 1;
      lat = lat_of(i);
      e_rd = 1'b0; e_val = 1'b0; e_addr = 0; e_smp = '0;
      if (((t - 1) % DIV == 0) && (m_loop || ((t - 1) / DIV) < len)) begin
        e_rd   = 1'b1;
        e_addr = (s + ((t - 1) / DIV) % len) % m;
      end
      if (t >= 2 + lat) begin
        ph = t - 2 - lat;
        k  = ph / DIV;
        if (!m_loop && k > len - 1) k = len - 1;
        e_smp = rom_fn(32'((s + k % len) % m), salt);
        e_val = (ph % DIV == 0) && (m_loop || (ph / DIV) < len);
      end
      e_done = !m_loop && (t >= 2 + lat + (len - 1) * DIV);
      chk($sformatf("d%0d t%0d rd", i, t), 64'(obs_rd[i]), 64'(e_rd));
      if (e_rd) chk($sformatf("d%0d t%0d addr", i, t), 64'(obs_addr[i]), 64'(e_addr));
      chk($sformatf("d%0d t%0d valid", i, t), 64'(obs_valid[i]), 64'(e_val));
      chk($sformatf("d%0d t%0d sample", i, t), 64'(obs_sample[i]), 64'(e_smp));
      chk($sformatf("d%0d t%0d done", i, t), 64'(obs_done[i]), 64'(e_done));
      chk($sformatf("d%0d t%0d busy", i, t), 64'(obs_busy[i]), 64'd1);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with all instances idle; start/end are scrambled
  // during play since only the values latched at IDLE exit may matter.
  task automatic play(input int s, input int e, input bit lp, input int ncyc, input bit use_rst);
    start_i = 10'(s);
    end_i   = 10'(e);
    loop_i  = lp;
    en      = 1'b1;
    m_start = s;
    m_end   = e;
    m_loop  = lp;
    for (int t = 1; t <= ncyc; t++) begin
      @(posedge clk);
      @(negedge clk);
      check_cycle(t);
      start_i = 10'($urandom);
      end_i   = 10'($urandom);
    end
    if (use_rst) begin
      #1 rst = 1'b1;
      #1 check_idle("async_rst", 1'b1);
      @(negedge clk);
      rst = 1'b0;
    end else begin
      en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_idle("abort", 1'b0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_idle("por", 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_rst", 1'b1);

    salt = 32'd16;
    play(0, 3, 1'b0, 40, 1'b0);
    play(0, 3, 1'b1, 50, 1'b0);
    play(14, 1, 1'b0, 40, 1'b0);
    play(5, 9, 1'b0, 2, 1'b0);
    play(5, 9, 1'b0, 30, 1'b0);
    play(2, 5, 1'b0, 6, 1'b1);
    play(7, 7, 1'b0, 24, 1'b0);

    for (int r = 0; r < 24; r++) begin
      int s, e;
      salt = $urandom;
      s = $urandom_range(0, 1023);
      if ($urandom_range(0, 2) == 0) e = $urandom_range(0, 1023);
      else e = (s + $urandom_range(0, 5)) % 1024;
      play(s, e, 1'($urandom_range(0, 1)), $urandom_range(3, 70),
           ($urandom_range(0, 4) == 0));
    end

    if (en) begin
      en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_idle("final", 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/audio_sample_fetch.md
AUDIO_SAMPLE_FETCH -- requirements
Module: audio_sample_fetch

Interface
REQ-001 Parameter ADDR_W, default 10, sample-ROM address width.
REQ-002 Parameter DATA_W, default 32, sample word width; matches PWM stage data input.
REQ-003 Parameter DIV, default 1024, clk cycles per sample period; legal range DIV >= ROM_LAT+3.
REQ-004 Parameter ROM_LAT, default 1, ROM read latency in clk cycles (0 = combinational ROM).
REQ-005 Port clk  in  1  single clock; all state on rising edge.
REQ-006 Port rst  in  1  asynchronous, active-high reset.
REQ-007 Port en  in  1  play enable; synchronous to clk (sync_trig output).
REQ-008 Port loop  in  1  1 = restart at start_addr after end_addr; sampled when end_addr is fetched.
REQ-009 Port start_addr  in  ADDR_W  first sample address; sampled on IDLE exit.
REQ-010 Port end_addr  in  ADDR_W  last sample address; sampled on IDLE exit.
REQ-011 Port rom_addr  out  ADDR_W  ROM read address, registered.
REQ-012 Port rom_rd  out  1  one-cycle ROM read strobe.
REQ-013 Port rom_data  in  DATA_W  ROM read data, valid ROM_LAT cycles after rom_rd.
REQ-014 Port sample  out  DATA_W  held sample to PWM stage, registered.
REQ-015 Port sample_valid  out  1  one-cycle pulse when sample updates.
REQ-016 Port busy  out  1  high in every state except IDLE.
REQ-017 Port done  out  1  high in DONE.

Function
REQ-018 FSM states IDLE, FETCH, WAIT_DATA, WAIT_TICK, DONE; state, address and tick counters registered.
REQ-019 IDLE: en=1 -> FETCH next edge; latch start_addr/end_addr into internal cur/last registers; tick counter cleared to 0.
REQ-020 FETCH: rom_addr=cur, rom_rd=1 for exactly this cycle; -> WAIT_DATA (ROM_LAT>0) or capture same cycle (ROM_LAT=0).
REQ-021 WAIT_DATA: count ROM_LAT cycles after rom_rd; on the edge ending the ROM_LAT-th cycle, sample<=rom_data, sample_valid=1 for the following cycle.
REQ-022 After capture: cur==last and loop=0 -> DONE; cur==last and loop=1 -> cur<=start latch, WAIT_TICK; else cur<=cur+1 modulo 2^ADDR_W, WAIT_TICK.
REQ-023 Tick counter runs 0..DIV-1 continuously while busy, cleared on IDLE exit; tick = count==DIV-1; consecutive rom_rd pulses exactly DIV cycles apart.
REQ-024 WAIT_TICK: on tick -> FETCH.
REQ-025 DONE: sample held at last value, done=1; en=0 -> IDLE.
REQ-026 start_addr > end_addr: address wraps through 2^ADDR_W-1 to 0 and continues to end_addr; start==end plays one sample.
REQ-027 en=0 in any non-IDLE state: -> IDLE next edge, sample<=0 (silence), sample_valid=0, rom_rd=0, in-flight read discarded.
REQ-028 en=0 and read capture on same edge: abort wins; capture discarded.
REQ-029 start_addr/end_addr/loop changes while busy have no effect except loop at end_addr capture.
REQ-030 rom_rd never asserted outside FETCH; at most one read outstanding.

Reset
REQ-031 rst=1 asynchronously forces IDLE, rom_addr=0, rom_rd=0, sample=0, sample_valid=0, busy=0, done=0, counters=0.
REQ-032 Release of rst while en=1: FETCH on first edge after release, no other special case.

Verification
REQ-033 DIV=8, ROM_LAT=1, start=0, end=3, loop=0, ROM[a]=a+16, en=1 -> rom_rd at cycles 1,9,17,25; sample 16,17,18,19 each with one valid pulse; done=1 after 4th capture.
REQ-034 Same setup, loop=1 -> address sequence 0,1,2,3,0,1 with rom_rd every 8 cycles; done stays 0.
REQ-035 ADDR_W=4, start=14, end=1 -> addresses 14,15,0,1 then DONE.
REQ-036 en dropped one cycle after a rom_rd -> no sample_valid, sample=0, IDLE next edge; en re-raised -> restarts at start_addr.
REQ-037 rst pulsed mid-WAIT_TICK with sample=0x12 -> all outputs 0 immediately, no clk edge needed.
REQ-038 ROM_LAT=0 and ROM_LAT=3 runs of REQ-033 -> identical sample sequence and 8-cycle rom_rd spacing.
